// File: rtl/inst_dec_pipe.sv
// Decode stage: register file, immediate generator, load-use stall and the ID/EX register.
// Optional macro WB_BYPASS_EN selects write-first register reads for same-cycle write-back.
module inst_dec_pipe #(
  parameter int XLEN = 32,
  parameter int PC_W = 64,
  parameter int NREG = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_if_id_valid,
  input  logic [PC_W-1:0] i_if_id_pc,
  input  logic [31:0]     i_if_id_inst,
  input  logic            i_flush,
  input  logic            i_ex_mem_read,
  input  logic [4:0]      i_ex_rd,
  input  logic            i_wb_reg_wr,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_stall,
  output logic            o_id_ex_valid,
  output logic [PC_W-1:0] o_id_ex_pc,
  output logic [XLEN-1:0] o_id_ex_rs1_data,
  output logic [XLEN-1:0] o_id_ex_rs2_data,
  output logic [XLEN-1:0] o_id_ex_imm,
  output logic [4:0]      o_id_ex_rs1,
  output logic [4:0]      o_id_ex_rs2,
  output logic [4:0]      o_id_ex_rd
);

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } id_ex_t;

  logic [NREG-1:0][XLEN-1:0] r_regs;
  id_ex_t                    r_id_ex;
  id_ex_t                    w_dec;

  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [6:0]  w_opc;
  logic        w_i_t, w_s_t, w_b_t, w_u_t, w_j_t;
  logic        w_rs1_used, w_rs2_used, w_hazard;
  logic [31:0] w_imm32;
  logic [XLEN-1:0] w_imm, w_rf1, w_rf2, w_op1, w_op2;

  assign w_rs1 = i_if_id_inst[19:15];
  assign w_rs2 = i_if_id_inst[24:20];
  assign w_rd  = i_if_id_inst[11:7];
  assign w_opc = i_if_id_inst[6:0];

  assign w_i_t = (w_opc == 7'b0000011) || (w_opc == 7'b0010011) ||
                 (w_opc == 7'b0011011) || (w_opc == 7'b1100111);
  assign w_s_t = (w_opc == 7'b0100011);
  assign w_b_t = (w_opc == 7'b1100011);
  assign w_u_t = (w_opc == 7'b0110111) || (w_opc == 7'b0010111);
  assign w_j_t = (w_opc == 7'b1101111);

  assign w_rs1_used = ~(w_u_t | w_j_t);
  assign w_rs2_used = (w_opc == 7'b0110011) || (w_opc == 7'b0111011) || w_s_t || w_b_t;

  always_comb begin
    w_imm32 = '0;
    if (w_i_t)      w_imm32 = {{20{i_if_id_inst[31]}}, i_if_id_inst[31:20]};
    else if (w_s_t) w_imm32 = {{20{i_if_id_inst[31]}}, i_if_id_inst[31:25], i_if_id_inst[11:7]};
    else if (w_b_t) w_imm32 = {{20{i_if_id_inst[31]}}, i_if_id_inst[7], i_if_id_inst[30:25],
                               i_if_id_inst[11:8], 1'b0};
    else if (w_u_t) w_imm32 = {i_if_id_inst[31:12], 12'b0};
    else if (w_j_t) w_imm32 = {{12{i_if_id_inst[31]}}, i_if_id_inst[19:12], i_if_id_inst[20],
                               i_if_id_inst[30:21], 1'b0};
  end

  // Top bit replicated at least once so XLEN=32 needs no zero-width replication.
  assign w_imm = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};

  assign w_rf1 = (w_rs1 != 5'd0 && 32'(w_rs1) < NREG) ? r_regs[w_rs1] : '0;
  assign w_rf2 = (w_rs2 != 5'd0 && 32'(w_rs2) < NREG) ? r_regs[w_rs2] : '0;

`ifdef WB_BYPASS_EN
  assign w_op1 = (i_wb_reg_wr && i_wb_rd != 5'd0 && i_wb_rd == w_rs1) ? i_wb_data : w_rf1;
  assign w_op2 = (i_wb_reg_wr && i_wb_rd != 5'd0 && i_wb_rd == w_rs2) ? i_wb_data : w_rf2;
`else
  assign w_op1 = w_rf1;
  assign w_op2 = w_rf2;
`endif

  assign w_hazard = i_if_id_valid & i_ex_mem_read & (i_ex_rd != 5'd0) &
                    ((w_rs1_used & (i_ex_rd == w_rs1)) | (w_rs2_used & (i_ex_rd == w_rs2)));
  assign o_stall  = w_hazard & ~i_flush;

  always_comb begin
    w_dec          = '0;
    w_dec.valid    = i_if_id_valid;
    w_dec.pc       = i_if_id_pc;
    w_dec.rs1_data = w_op1;
    w_dec.rs2_data = w_op2;
    w_dec.imm      = w_imm;
    w_dec.rs1      = w_rs1;
    w_dec.rs2      = w_rs2;
    w_dec.rd       = w_rd;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_regs <= '0;
    end else if (i_wb_reg_wr && i_wb_rd != 5'd0 && 32'(i_wb_rd) < NREG) begin
      r_regs[i_wb_rd] <= i_wb_data;
    end
  end

  // Flush and hazard both collapse to an all-zero bubble.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                   r_id_ex <= '0;
    else if (i_flush || w_hazard) r_id_ex <= '0;
    else                         r_id_ex <= w_dec;
  end

  assign o_id_ex_valid    = r_id_ex.valid;
  assign o_id_ex_pc       = r_id_ex.pc;
  assign o_id_ex_rs1_data = r_id_ex.rs1_data;
  assign o_id_ex_rs2_data = r_id_ex.rs2_data;
  assign o_id_ex_imm      = r_id_ex.imm;
  assign o_id_ex_rs1      = r_id_ex.rs1;
  assign o_id_ex_rs2      = r_id_ex.rs2;
  assign o_id_ex_rd       = r_id_ex.rd;

endmodule

// File: doc/inst_dec_pipe.md
# inst_dec_pipe

Parametrised instruction-decode stage that sits between the IF/ID and ID/EX pipeline boundaries. It contains the integer register file and an RV32I/RV64I immediate generator, and it registers the decoded fields into the ID/EX pipeline register. Compared with the earlier decode stage it adds an ID/EX valid bit, load-use hazard detection with a stall output, branch flush, configurable datapath/PC width and an optional write-back bypass.

## Interface
- XLEN, 32, datapath and register width (32 or 64)
- PC_W, 64, program-counter width
- NREG, 32, number of architectural registers (index width fixed at 5)

- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous reset, active-high
- i_if_id_valid  in  1  IF/ID holds a real instruction
- i_if_id_pc  in  PC_W  PC of the instruction in IF/ID
- i_if_id_inst  in  32  instruction word
- i_flush  in  1  taken branch/jump resolved in EX; kill the instruction in ID
- i_ex_mem_read  in  1  instruction currently in EX is a load
- i_ex_rd  in  5  destination register of the EX instruction
- i_wb_reg_wr  in  1  write-back enable
- i_wb_rd  in  5  write-back register index
- i_wb_data  in  XLEN  write-back data
- o_stall  out  1  hold PC and IF/ID this cycle (combinational)
- o_id_ex_valid  out  1  ID/EX holds a real instruction
- o_id_ex_pc  out  PC_W  registered PC
- o_id_ex_rs1_data / o_id_ex_rs2_data  out  XLEN  registered operands
- o_id_ex_imm  out  XLEN  registered sign-extended immediate
- o_id_ex_rs1 / o_id_ex_rs2 / o_id_ex_rd  out  5  registered register indices, used by EX forwarding

## Operation
- Fields: rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7], opcode = inst[6:0].
- Register file: NREG×XLEN. x0 always reads 0, and writes to x0 are dropped. Writes occur on the rising edge when i_wb_reg_wr=1.
- Immediate, sign-extended from bit 31 to XLEN:
  - I-type for 0000011, 0010011, 0011011, 1100111
  - S-type for 0100011
  - B-type for 1100011 (bit 0 = 0)
  - U-type for 0110111, 0010111 (low 12 bits = 0)
  - J-type for 1101111 (bit 0 = 0)
  - any other opcode produces 0
- Source usage:
  - rs1 is used unless the opcode is U- or J-type.
  - rs2 is used only for 0110011, 0111011, 0100011, 1100011.
- Load-use hazard: i_if_id_valid & i_ex_mem_read & i_ex_rd≠0 & ((rs1 used & i_ex_rd==rs1) | (rs2 used & i_ex_rd==rs2)).
- o_stall = hazard & ~i_flush.
- ID/EX update on each rising edge (priority order):
  - i_flush: bubble.
  - hazard: bubble. IF/ID is held upstream, so the instruction re-decodes next cycle.
  - otherwise: load decoded fields, with o_id_ex_valid = i_if_id_valid.
- Bubble: o_id_ex_valid=0 and o_id_ex_rd=0. All other ID/EX fields are zero.

## Timing
- Reset (asynchronous, i_rst=1): all ID/EX outputs = 0, all registers = 0, o_stall follows its inputs (combinational). Reset asserted mid-stall clears ID/EX immediately, and the register file contents are lost.
- Latency: 1 cycle from IF/ID inputs to ID/EX outputs.
- o_stall is combinational from the current inputs and asserts in the same cycle as the hazard. It lasts exactly one cycle per load-use pair, because the load advances out of EX.
- Same-cycle flush and hazard: the flush wins, o_stall=0, and a bubble is inserted.
- Same-cycle WB write and ID read of the same register: see Configuration.
- Register file write and ID/EX capture occur on the same edge.

## Configuration
- WB_BYPASS_EN
  - Defined: when i_wb_reg_wr=1, i_wb_rd≠0 and i_wb_rd matches rs1 or rs2, the matching operand captured into ID/EX is i_wb_data (write-first).
  - Undefined: the operand is the pre-write register value. EX forwarding must cover this case.

## Test plan
- Reset with i_rst=1 mid-run → every o_id_ex_* = 0 immediately. After release, a read of x5 returns 0.
- Write x5=0xDEADBEEF via WB, then decode `addi x6,x5,-1` (0xFFF28313) → next cycle rs1_data=0xDEADBEEF, imm=0xFFFFFFFF, rd=6, valid=1.
- EX load with rd=5 while ID decodes `add x7,x5,x1` → o_stall=1 for one cycle and an ID/EX bubble. The following cycle the add issues with valid=1.
- The same hazard with i_flush=1 → o_stall=0 and valid=0 on the next edge.
- Decode `beq` with offset −4 (0xFE000EE3), `jal` (0x0080006F), `lui` (0x123452B7) → imm = 0xFFFFFFFC, 0x00000008, 0x12345000 respectively.
- WB writes x9=0x55 in the same cycle ID reads x9 → captured value is 0x55 with WB_BYPASS_EN defined, and the old value without it. A WB write to x0 → x0 still reads 0.
